branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 128 ++++++++++++
 tb/tb_branch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates branches and jumps, registers the outcome one cycle later,
// and keeps a 2-bit bimodal predictor table plus saturating branch/mispredict statistics.
module branch_unit #(
  parameter int P_XLEN      = 32,
  parameter int P_BHT_DEPTH = 64
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic [P_XLEN-1:0] ilookup_pc,
  output logic              opred_taken,
  input  logic              ivalid,
  input  logic              iflush,
  input  logic [6:0]        iop,
  input  logic [2:0]        ifunct3,
  input  logic              ipred_taken,
  input  logic [P_XLEN-1:0] ipc,
  input  logic [P_XLEN-1:0] irs1,
  input  logic [P_XLEN-1:0] irs2,
  input  logic [P_XLEN-1:0] iimm,
  output logic              ovalid,
  output logic              otaken,
  output logic              omispredict,
  output logic [P_XLEN-1:0] oredirect_pc,
  output logic              oillegal,
  output logic [31:0]       obr_count,
  output logic [31:0]       omiss_count
);

  localparam int IDX_W = $clog2(P_BHT_DEPTH);
  localparam logic [P_XLEN-1:0] PC_STEP   = P_XLEN'(4);
  localparam logic [P_XLEN-1:0] CLR_BIT0  = ~P_XLEN'(1);

  typedef enum logic [6:0] {
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  logic [1:0]        bht [P_BHT_DEPTH];
  logic [IDX_W-1:0]  lookup_idx;
  logic [IDX_W-1:0]  update_idx;
  logic              is_br, is_jal, is_jalr;
  logic              cond, illegal, taken, mispredict, accept, bht_we;
  logic [P_XLEN-1:0] jalr_sum, target, redirect;
  logic [1:0]        ctr_cur, ctr_next;

  // Lookup-PC bits outside the table index are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ilookup_pc[P_XLEN-1:IDX_W+2], ilookup_pc[1:0]};

  assign lookup_idx  = ilookup_pc[IDX_W+1:2];
  assign update_idx  = ipc[IDX_W+1:2];
  assign opred_taken = bht[lookup_idx][1];

  assign is_br   = (iop == OP_BRANCH);
  assign is_jal  = (iop == OP_JAL);
  assign is_jalr = (iop == OP_JALR);
  assign accept  = ivalid & ~iflush;

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    cond = 1'b0;
    case (ifunct3)
      3'b000:  cond = (irs1 == irs2);
      3'b001:  cond = (irs1 != irs2);
      3'b100:  cond = ($signed(irs1) <  $signed(irs2));
      3'b101:  cond = ($signed(irs1) >= $signed(irs2));
      3'b110:  cond = (irs1 <  irs2);
      3'b111:  cond = (irs1 >= irs2);
      default: cond = 1'b0;
    endcase
  end

  assign illegal  = is_br & ((ifunct3 == 3'b010) | (ifunct3 == 3'b011));
  assign taken    = is_jal | is_jalr | (is_br & ~illegal & cond);
  assign jalr_sum = irs1 + iimm;
  assign target   = is_jalr ? (jalr_sum & CLR_BIT0) : (ipc + iimm);
  assign redirect = taken ? target : (ipc + PC_STEP);

  always_comb begin
    mispredict = ipred_taken;
    if (is_br)        mispredict = (taken != ipred_taken);
    else if (is_jal)  mispredict = ~ipred_taken;
    else if (is_jalr) mispredict = 1'b1;
  end

  assign bht_we  = accept & is_br & ~illegal;
  assign ctr_cur = bht[update_idx];
  always_comb begin
    ctr_next = ctr_cur;
    if (taken && ctr_cur != 2'b11)       ctr_next = ctr_cur + 2'b01;
    else if (!taken && ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
  end

  // NOTE: the predictor table is reset like any flop because every entry must start at weakly
  // not-taken; this forces it into registers rather than a RAM macro.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < P_BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (bht_we) begin
      bht[update_idx] <= ctr_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ovalid       <= 1'b0;
      otaken       <= 1'b0;
      omispredict  <= 1'b0;
      oillegal     <= 1'b0;
      oredirect_pc <= '0;
      obr_count    <= '0;
      omiss_count  <= '0;
    end else begin
      ovalid      <= accept;
      otaken      <= accept & taken;
      omispredict <= accept & mispredict;
      oillegal    <= accept & illegal;
      if (accept) oredirect_pc <= redirect;
      if (accept && (is_br || is_jal || is_jalr) && obr_count != '1)
        obr_count <= obr_count + 32'd1;
      if (accept && mispredict && omiss_count != '1)
        omiss_count <= omiss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit: resolution, predictor training, flush,
// illegal funct3 and asynchronous reset in mid-stream.
module tb_branch_unit;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic [31:0] ilookup_pc;
  logic        opred_taken;
  logic        ivalid, iflush, ipred_taken;
  logic [6:0]  iop;
  logic [2:0]  ifunct3;
  logic [31:0] ipc, irs1, irs2, iimm;
  logic        ovalid, otaken, omispredict, oillegal;
  logic [31:0] oredirect_pc, obr_count, omiss_count;

  int n_checks = 0;
  int n_errors = 0;
  int br_exp   = 0;
  int miss_exp = 0;

  branch_unit dut (
    .iclk(iclk), .irst_n(irst_n), .ilookup_pc(ilookup_pc), .opred_taken(opred_taken),
    .ivalid(ivalid), .iflush(iflush), .iop(iop), .ifunct3(ifunct3),
    .ipred_taken(ipred_taken), .ipc(ipc), .irs1(irs1), .irs2(irs2), .iimm(iimm),
    .ovalid(ovalid), .otaken(otaken), .omispredict(omispredict),
    .oredirect_pc(oredirect_pc), .oillegal(oillegal),
    .obr_count(obr_count), .omiss_count(omiss_count)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic pred);
    ivalid = 1'b1; iflush = 1'b0; iop = op; ifunct3 = f3;
    ipc = pc; irs1 = rs1; irs2 = rs2; iimm = imm; ipred_taken = pred;
  endtask

  task automatic idle();
    ivalid = 1'b0; iflush = 1'b0; iop = OP_ALU; ifunct3 = 3'b000; ipred_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic expect_out(input string tag, input logic tk, input logic mp, input logic il,
                            input logic [31:0] rd, input logic chk_cnt);
    check({tag, ".valid"},    ovalid,       1'b1);
    check({tag, ".taken"},    otaken,       tk);
    check({tag, ".misp"},     omispredict,  mp);
    check({tag, ".illegal"},  oillegal,     il);
    check({tag, ".redirect"}, oredirect_pc, rd);
    if (chk_cnt) begin
      check({tag, ".br_cnt"},   obr_count,   64'(br_exp));
      check({tag, ".miss_cnt"}, omiss_count, 64'(miss_exp));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},    ovalid,       1'b0);
    check({tag, ".taken"},    otaken,       1'b0);
    check({tag, ".misp"},     omispredict,  1'b0);
    check({tag, ".illegal"},  oillegal,     1'b0);
    check({tag, ".redirect"}, oredirect_pc, 32'h0);
    check({tag, ".br_cnt"},   obr_count,    32'h0);
    check({tag, ".miss_cnt"}, omiss_count,  32'h0);
  endtask

  initial begin
    logic exp_train [4];
    exp_train = '{1'b0, 1'b1, 1'b1, 1'b1};

    irst_n = 1'b0; ilookup_pc = 32'h40;
    ipc = '0; irs1 = '0; irs2 = '0; iimm = '0;
    idle();
    #1;
    check_zero("reset");
    check("reset.pred40", opred_taken, 1'b0);
    @(negedge iclk);
    irst_n = 1'b1;
    @(negedge iclk);

    // BEQ equal operands, predicted not-taken
    send(OP_BR, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
    step(); br_exp++; miss_exp++;
    expect_out("beq", 1'b1, 1'b1, 1'b0, 32'h120, 1'b1);

    // BLT signed: -1 < 1
    send(OP_BR, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1);
    step(); br_exp++;
    expect_out("blt", 1'b1, 1'b0, 1'b0, 32'h210, 1'b1);

    // BLTU: 0xFFFFFFFF is not below 1
    send(OP_BR, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1);
    step(); br_exp++; miss_exp++;
    expect_out("bltu", 1'b0, 1'b1, 1'b0, 32'h204, 1'b1);

    // BGE with equal operands is taken
    send(OP_BR, 3'b101, 32'h300, 32'd7, 32'd7, 32'h8, 1'b1);
    step(); br_exp++;
    expect_out("bge_eq", 1'b1, 1'b0, 1'b0, 32'h308, 1'b1);

    // BNE with equal operands falls through
    send(OP_BR, 3'b001, 32'h310, 32'd7, 32'd7, 32'h8, 1'b0);
    step(); br_exp++;
    expect_out("bne_eq", 1'b0, 1'b0, 1'b0, 32'h314, 1'b1);

    // JALR: (0x1001 + 4) with bit0 cleared, always a redirect
    send(OP_JALR, 3'b000, 32'h400, 32'h1001, 32'h0, 32'h4, 1'b1);
    step(); br_exp++; miss_exp++;
    expect_out("jalr", 1'b1, 1'b1, 1'b0, 32'h1004, 1'b1);

    // JAL backwards, correctly predicted
    send(OP_JAL, 3'b000, 32'h500, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b1);
    step(); br_exp++;
    expect_out("jal", 1'b1, 1'b0, 1'b0, 32'h4F0, 1'b1);

    // Non-control instruction wrongly predicted taken
    send(OP_ALU, 3'b000, 32'h600, 32'h0, 32'h0, 32'h0, 1'b1);
    step(); miss_exp++;
    expect_out("alu", 1'b0, 1'b1, 1'b0, 32'h604, 1'b1);

    // Train PC 0x40: prediction before each update reads 0,1,1,1 (01->10->11->11)
    ilookup_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      send(OP_BR, 3'b000, 32'h40, 32'd9, 32'd9, 32'h10, 1'b0);
      #1;
      check($sformatf("train%0d.pred", i), opred_taken, exp_train[i]);
      step(); br_exp++; miss_exp++;
      expect_out($sformatf("train%0d", i), 1'b1, 1'b1, 1'b0, 32'h50, 1'b1);
    end
    check("train.sat_pred", opred_taken, 1'b1);

    // Two not-taken: 11->10->01
    for (int i = 0; i < 2; i++) begin
      send(OP_BR, 3'b001, 32'h40, 32'd9, 32'd9, 32'h10, 1'b0);
      #1;
      check($sformatf("dec%0d.pred", i), opred_taken, 1'b1);
      step(); br_exp++;
      expect_out($sformatf("dec%0d", i), 1'b0, 1'b0, 1'b0, 32'h44, 1'b1);
    end
    check("dec.pred", opred_taken, 1'b0);

    // Flush wins over valid: no output, no counter or table change
    send(OP_BR, 3'b000, 32'h80, 32'd1, 32'd1, 32'h10, 1'b0);
    iflush = 1'b1; ilookup_pc = 32'h80;
    step();
    check("flush.valid",    ovalid,      1'b0);
    check("flush.taken",    otaken,      1'b0);
    check("flush.misp",     omispredict, 1'b0);
    check("flush.br_cnt",   obr_count,   64'(br_exp));
    check("flush.miss_cnt", omiss_count, 64'(miss_exp));
    check("flush.pred80",   opred_taken, 1'b0);
    idle();

    // Bump 0x40 to 10, then an illegal funct3 must not decrement it
    ilookup_pc = 32'h40;
    send(OP_BR, 3'b000, 32'h40, 32'd3, 32'd3, 32'h10, 1'b0);
    step(); br_exp++; miss_exp++;
    expect_out("bump", 1'b1, 1'b1, 1'b0, 32'h50, 1'b1);
    check("bump.pred", opred_taken, 1'b1);
    send(OP_BR, 3'b010, 32'h40, 32'd3, 32'd3, 32'h10, 1'b0);
    step();
    expect_out("illegal", 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
    check("illegal.pred", opred_taken, 1'b1);

    // Reset mid-stream with a request in flight
    send(OP_BR, 3'b000, 32'h40, 32'd3, 32'd3, 32'h10, 1'b1);
    step();
    check("pre_rst.valid", ovalid, 1'b1);
    send(OP_BR, 3'b000, 32'h40, 32'd3, 32'd3, 32'h10, 1'b0);
    #2 irst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    check("mid_rst.pred", opred_taken, 1'b0);
    br_exp = 0; miss_exp = 0;
    @(posedge iclk);
    @(negedge iclk);
    irst_n = 1'b1;
    idle();
    step();
    check("post_rst.valid", ovalid, 1'b0);

    // Table back at 01: one taken update flips the prediction
    send(OP_BR, 3'b000, 32'h40, 32'd3, 32'd3, 32'h10, 1'b0);
    #1;
    check("post_rst.pred_before", opred_taken, 1'b0);
    step(); br_exp++; miss_exp++;
    expect_out("post_rst", 1'b1, 1'b1, 1'b0, 32'h50, 1'b1);
    check("post_rst.pred_after", opred_taken, 1'b1);
    idle();
    step();
    check("end.valid", ovalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
